axis_pcie_tx_arb: RTL and testbench
===================================

# axis_pcie_tx_arb

Packet-atomic round-robin arbiter that shares the single PCIe TX AXI-Stream channel among NUM_PORTS requesters (host-channel DMA, MMIO read completions, interrupt/message generators). It sits between the requesters and the TX pipeline register chain in front of the PCIe subsystem. A multi-beat TLP, once started, owns the channel until its `tlast` beat is accepted. The output is registered through one skid-buffer stage so timing is closed on the shared link.

## Interface
Parameters:
- NUM_PORTS, 2: number of requesters; legal range 2..8.
- PTR_W, $clog2(NUM_PORTS): derived; width of the port index.

Ports:
- clk  in  1  interface clock; all logic is in this single domain.
- rst_n  in  1  asynchronous, active-low reset.
- s_if  in  t_axis_pcie_tx[NUM_PORTS]  requester streams (tvalid, tdata, tlast, tuser).
- s_if_tready  out  NUM_PORTS  per-requester ready.
- m_if  out  t_axis_pcie_tx  arbitrated stream toward the TX pipeline.
- m_if_tready  in  1  downstream ready.
- grant_idx  out  PTR_W  index of the port currently owning the channel; valid while `grant_active` is high.
- grant_active  out  1  high while in LOCKED, or in IDLE when a beat is accepted.
- pkt_cnt  out  32×NUM_PORTS  per-port TLP counters. Present only with the macro.

## Operation
- Internal output stage: a skid buffer with 2 entries. `stage_ready` is high when the skid buffer is not full.
- State IDLE:
  - A combinational round-robin pick selects the first asserted `s_if[i].tvalid`, searching from `last_grant+1` and wrapping modulo NUM_PORTS.
  - `s_if_tready[pick] = stage_ready`; all other ready signals are 0.
  - On an accepted beat with `tlast=1`: stay in IDLE and set `last_grant <= pick`.
  - On an accepted beat with `tlast=0`: go to LOCKED with `owner <= pick`.
- State LOCKED:
  - Only `s_if_tready[owner] = stage_ready`.
  - Bubbles (owner `tvalid` low) keep the lock.
  - Other requesters are never granted, even if they hold valid data.
  - On an accepted `tlast` beat: go to IDLE and set `last_grant <= owner`.
- Requester `tvalid` for a beat that has not been accepted does not change the grant. Once in IDLE, the pick is recomputed every cycle until a beat is accepted.
- Beat content (tdata, tuser, tlast) is passed through unmodified. There is no reordering within a port.
- Reset values:
  - All `s_if_tready` = 0.
  - `m_if.tvalid` = 0; `m_if.tlast` = 0.
  - `tdata`/`tuser` = don't care.
  - State = IDLE.
  - `last_grant` = NUM_PORTS-1, so port 0 has first priority.
  - `grant_active` = 0; `grant_idx` = 0.
  - `pkt_cnt` = 0.
- Reset mid-packet: the lock, the skid contents and the partial TLP are discarded. Requesters must restart their TLPs after reset.

## Timing
- Latency: an accepted input beat appears on `m_if` on the next cycle when `m_if_tready` is high.
- Throughput: 1 beat/cycle sustained, including back-to-back single-beat TLPs from different ports. There are no arbitration bubbles.
- `s_if_tready` never depends combinationally on `m_if_tready`; it is derived from the skid buffer occupancy only.
- `m_if.tvalid`, once asserted, holds with stable data until `m_if_tready` is high (AXIS rule).
- The output stage never drops or duplicates beats.
- Simultaneous events in the same cycle: a `tlast` accept on the owner and new `tvalid` from other ports. The grant switches on the following cycle using the updated `last_grant`.

## Configuration
- `OFS_PCIE_TX_ARB_PERF_EN`
  - Defined: `pkt_cnt[i]` increments by 1 on each accepted `tlast` beat of port i. The counter is 32-bit and wraps from 0xFFFF_FFFF to 0.
  - Not defined: the port and the counters are absent and no counter logic is synthesized.

## Structure
- Put `t_axis_pcie_tx`, `AXIS_PCIE_DW` and `AXIS_PCIE_TX_UW` in ofs_fim_if_pkg (existing).
- Add the arbiter state enum `t_tx_arb_state {IDLE, LOCKED}` to the same package.
- Implement the output stage with one instance of the existing `axis_register` (MODE 0 skid, ENABLE_TLAST=1, ENABLE_TUSER=1). The arbiter body itself needs no further sub-modules.

## Test plan
- Port 0 only, 3-beat TLP, `m_if_tready` held at 1: the beats leave on consecutive cycles with 1-cycle latency. `grant_idx`=0, `pkt_cnt[0]`=1.
- Ports 0/1/2 each send single-beat TLPs continuously: the output order is 0,1,2,0,1,2 at 1 beat/cycle.
- Port 1 sends 4 beats with a 2-cycle bubble after beat 2, while port 0 is valid the whole time: port 0 is not granted until port 1's `tlast` is accepted.
- `m_if_tready` toggles 1010…, then is held low for 5 cycles: no beat is lost or duplicated, `m_if` is stable while stalled, and `s_if_tready` drops once the skid buffer is full.
- Assert `rst_n` low in the middle of beat 2 of a 4-beat TLP: all outputs reach their reset values immediately, and after release port 0 wins first.
- With the macro defined, send 10 TLPs on port 2: `pkt_cnt[2]`=10 and all other counters are 0. Preload a counter to 0xFFFF_FFFF and send one more TLP: the counter wraps to 0.

Source files
------------

// File: rtl/ofs_fim_if_pkg.sv
// Shared PCIe TX AXI-Stream types and the TX arbiter state encoding.
package ofs_fim_if_pkg;

  localparam int AXIS_PCIE_DW    = 64;
  localparam int AXIS_PCIE_TX_UW = 8;

  typedef struct packed {
    logic                       tvalid;
    logic                       tlast;
    logic [AXIS_PCIE_TX_UW-1:0] tuser;
    logic [AXIS_PCIE_DW-1:0]    tdata;
  } t_axis_pcie_tx;

  typedef enum logic {
    IDLE,
    LOCKED
  } t_tx_arb_state;

endpackage

// File: rtl/axis_pcie_tx_arb_if.sv
// Bundle of requester streams, per-requester ready, arbitrated output and its ready.
// slave: the arbiter side; master: requesters plus downstream sink.
interface axis_pcie_tx_arb_if
  import ofs_fim_if_pkg::*;
#(
  parameter int NUM_PORTS = 2
);

  t_axis_pcie_tx [NUM_PORTS-1:0] s_if;
  logic [NUM_PORTS-1:0]          s_if_tready;
  t_axis_pcie_tx                 m_if;
  logic                          m_if_tready;

  modport slave  (input  s_if, m_if_tready, output s_if_tready, m_if);
  modport master (output s_if, m_if_tready, input  s_if_tready, m_if);

endinterface

// File: rtl/axis_register.sv
// AXI-Stream register slice. MODE 0 is a two-entry skid buffer whose input
// ready is registered (depends only on occupancy); other modes pass straight through.
module axis_register #(
  parameter int MODE         = 0,
  parameter int TDATA_W      = 64,
  parameter int TUSER_W      = 8,
  parameter int ENABLE_TLAST = 1,
  parameter int ENABLE_TUSER = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic [TDATA_W-1:0] s_tdata,
  input  logic               s_tlast,
  input  logic [TUSER_W-1:0] s_tuser,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [TDATA_W-1:0] m_tdata,
  output logic               m_tlast,
  output logic [TUSER_W-1:0] m_tuser
);

  localparam int PW = TDATA_W + TUSER_W + 1;

  logic [PW-1:0] s_pld;
  logic [PW-1:0] m_pld;

  // With tlast disabled every beat is treated as a complete packet.
  assign s_pld = {(ENABLE_TUSER != 0) ? s_tuser : {TUSER_W{1'b0}},
                  (ENABLE_TLAST != 0) ? s_tlast : 1'b1,
                  s_tdata};
  assign {m_tuser, m_tlast, m_tdata} = m_pld;

  if (MODE == 0) begin : g_skid
    logic          main_valid, skid_valid, ready_q, take;
    logic [PW-1:0] main_pld, skid_pld;

    assign take     = s_tvalid && ready_q;
    assign s_tready = ready_q;
    assign m_tvalid = main_valid;
    assign m_pld    = main_pld;

    // Main entry drives the output; the skid entry catches the beat accepted during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        ready_q    <= 1'b0;
        main_pld   <= '0;
        skid_pld   <= '0;
      end else if (!main_valid || m_tready) begin
        ready_q <= 1'b1;
        if (skid_valid) begin
          main_pld   <= skid_pld;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= take;
          if (take) main_pld <= s_pld;
        end
      end else if (take) begin
        skid_pld   <= s_pld;
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end else begin
        ready_q <= !skid_valid;
      end
    end
  end else begin : g_pass
    assign s_tready = m_tready;
    assign m_tvalid = s_tvalid;
    assign m_pld    = s_pld;
  end

endmodule

// File: rtl/axis_pcie_tx_arb.sv
// Packet-atomic round-robin arbiter for the shared PCIe TX AXI-Stream channel.
// Optional macro OFS_PCIE_TX_ARB_PERF_EN adds per-port completed-TLP counters (pkt_cnt).
//
// state  | meaning
// IDLE   | no packet in flight; round-robin pick offered the channel each cycle
// LOCKED | multi-beat TLP of 'owner' in progress; only owner may send until tlast
module axis_pcie_tx_arb
  import ofs_fim_if_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  axis_pcie_tx_arb_if.slave           tx,
  output logic [PTR_W-1:0]            grant_idx,
  output logic                        grant_active
`ifdef OFS_PCIE_TX_ARB_PERF_EN
  , output logic [NUM_PORTS-1:0][31:0] pkt_cnt
`endif
);

  t_tx_arb_state           state, state_nxt;
  logic [PTR_W-1:0]        last_grant, owner, pick, sel;
  logic                    found, stage_ready, in_valid, accept;
  t_axis_pcie_tx           in_beat;
  logic                    m_tvalid, m_tlast;
  logic [AXIS_PCIE_DW-1:0]    m_tdata;
  logic [AXIS_PCIE_TX_UW-1:0] m_tuser;

  // Round-robin search for the first valid requester after the previous winner.
  always_comb begin
    logic [PTR_W-1:0] cand;
    cand  = '0;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PTR_W'((int'(last_grant) + k) % NUM_PORTS);
      if (!found && tx.s_if[cand].tvalid) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign sel      = (state == LOCKED) ? owner : pick;
  assign in_beat  = tx.s_if[sel];
  assign in_valid = (state == LOCKED) ? in_beat.tvalid : found;
  assign accept   = in_valid && stage_ready;

  // Ready goes only to the selected port and only follows output-stage occupancy.
  always_comb begin
    tx.s_if_tready = '0;
    if (state == LOCKED || found) tx.s_if_tready[sel] = stage_ready;
  end

  assign grant_active = (state == LOCKED) || accept;
  assign grant_idx    = (state == LOCKED) ? owner : (accept ? pick : '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Lock on the first beat of a multi-beat TLP, release on its tlast.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !in_beat.tlast) state_nxt = LOCKED;
      LOCKED:  if (accept &&  in_beat.tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner captured at packet start; last_grant advanced when a packet completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PTR_W'(NUM_PORTS - 1);
      owner      <= '0;
    end else if (accept) begin
      if (in_beat.tlast) last_grant <= sel;
      else               owner      <= sel;
    end
  end

  axis_register #(
    .MODE         (0),
    .TDATA_W      (AXIS_PCIE_DW),
    .TUSER_W      (AXIS_PCIE_TX_UW),
    .ENABLE_TLAST (1),
    .ENABLE_TUSER (1)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (in_valid),
    .s_tready (stage_ready),
    .s_tdata  (in_beat.tdata),
    .s_tlast  (in_beat.tlast),
    .s_tuser  (in_beat.tuser),
    .m_tvalid (m_tvalid),
    .m_tready (tx.m_if_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser)
  );

  assign tx.m_if = {m_tvalid, m_tlast, m_tuser, m_tdata};

`ifdef OFS_PCIE_TX_ARB_PERF_EN
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    logic [31:0] cnt_q;
    // Count completed TLPs of port i; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          cnt_q <= '0;
      else if (accept && in_beat.tlast && sel == PTR_W'(i)) cnt_q <= cnt_q + 32'd1;
    end
    assign pkt_cnt[i] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_axis_pcie_tx_arb.sv
// Bench for axis_pcie_tx_arb: queue-based reference model checked every cycle plus
// directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_axis_pcie_tx_arb;
  import ofs_fim_if_pkg::*;

  localparam int NP = 3;
  localparam int PW = $clog2(NP);

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  user;
    int          gap;
  } beat_t;

  typedef struct {
    int port;
    int seq;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] grant_idx;
  logic          grant_active;
`ifdef OFS_PCIE_TX_ARB_PERF_EN
  logic [NP-1:0][31:0] pkt_cnt;
`endif

  axis_pcie_tx_arb_if #(.NUM_PORTS(NP)) bus ();

  axis_pcie_tx_arb #(.NUM_PORTS(NP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx           (bus),
    .grant_idx    (grant_idx),
    .grant_active (grant_active)
`ifdef OFS_PCIE_TX_ARB_PERF_EN
    , .pkt_cnt    (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic beat_t mk(int p, int seq, bit last, int gap);
    beat_t b;
    b.data = {8'(p), 40'h0, 16'(seq)};
    b.last = last;
    b.user = 8'((p << 4) | (seq & 15));
    b.gap  = gap;
    return b;
  endfunction

  // ---------------- stimulus driver ----------------
  beat_t         tx_q [NP][$];
  int            wait_c [NP];
  bit            rdy_q [$];
  logic [NP-1:0] hs;
  int            cyc = 0;

  initial begin
    bus.s_if        = '0;
    bus.m_if_tready = 1'b1;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) hs[p] = bus.s_if[p].tvalid && bus.s_if_tready[p];
      @(posedge clk);
      cyc++;
      #1;
      for (int p = 0; p < NP; p++) begin
        if (!rst_n) begin
          tx_q[p].delete();
          wait_c[p] = 0;
        end else if (hs[p] && tx_q[p].size() > 0) begin
          void'(tx_q[p].pop_front());
          if (tx_q[p].size() > 0) wait_c[p] = tx_q[p][0].gap;
        end
        if (wait_c[p] > 0) begin
          bus.s_if[p].tvalid = 1'b0;
          wait_c[p]--;
        end else if (tx_q[p].size() > 0) begin
          bus.s_if[p].tvalid = 1'b1;
          bus.s_if[p].tdata  = tx_q[p][0].data;
          bus.s_if[p].tlast  = tx_q[p][0].last;
          bus.s_if[p].tuser  = tx_q[p][0].user;
        end else begin
          bus.s_if[p].tvalid = 1'b0;
        end
      end
      if (rdy_q.size() > 0) bus.m_if_tready = rdy_q.pop_front();
      else                  bus.m_if_tready = 1'b1;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit            m_locked;
  int            m_owner, m_last;
  beat_t         m_q [$];
  bit            m_rdy_ok;
  logic [31:0]   m_cnt [NP];
  ev_t           acc_log [$];
  ev_t           out_log [$];
  bit            prev_stall;
  logic [63:0]   prev_data;
  int            stall_run;
  bit            saw_full;
  logic [NP-1:0] v, exp_rdy;
  int            s;
  bit            act, sr;
  beat_t         nb;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_s_tready", 64'(bus.s_if_tready), 64'd0);
        chk("rst_m_tvalid", 64'(bus.m_if.tvalid), 64'd0);
        chk("rst_m_tlast", 64'(bus.m_if.tlast), 64'd0);
        chk("rst_grant_active", 64'(grant_active), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        m_locked = 0; m_owner = 0; m_last = NP - 1; m_rdy_ok = 0;
        m_q.delete(); acc_log.delete(); out_log.delete();
        for (int p = 0; p < NP; p++) m_cnt[p] = '0;
        prev_stall = 0; stall_run = 0; saw_full = 0;
      end else begin
        for (int p = 0; p < NP; p++) v[p] = bus.s_if[p].tvalid;
        sr      = m_rdy_ok && (m_q.size() < 2);
        exp_rdy = '0;
        act     = 0;
        s       = 0;
        if (m_locked) begin
          s   = m_owner;
          act = 1;
          if (sr) exp_rdy[s] = 1'b1;
        end else if (|v) begin
          for (int k = NP; k >= 1; k--)
            if (v[(m_last + k) % NP]) s = (m_last + k) % NP;
          if (sr) begin
            exp_rdy[s] = 1'b1;
            act        = 1;
          end
        end
        chk("s_tready", 64'(bus.s_if_tready), 64'(exp_rdy));
        chk("grant_active", 64'(grant_active), 64'(act));
        if (act) chk("grant_idx", 64'(grant_idx), 64'(s));
        chk("m_tvalid", 64'(bus.m_if.tvalid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
          chk("m_tdata", bus.m_if.tdata, m_q[0].data);
          chk("m_tlast", 64'(bus.m_if.tlast), 64'(m_q[0].last));
          chk("m_tuser", 64'(bus.m_if.tuser), 64'(m_q[0].user));
        end
        if (prev_stall) begin
          chk("stall_tvalid_hold", 64'(bus.m_if.tvalid), 64'd1);
          chk("stall_tdata_hold", bus.m_if.tdata, prev_data);
        end
`ifdef OFS_PCIE_TX_ARB_PERF_EN
        for (int p = 0; p < NP; p++) chk("pkt_cnt", 64'(pkt_cnt[p]), 64'(m_cnt[p]));
`endif
        if (bus.m_if.tvalid && bus.m_if_tready && m_q.size() > 0) begin
          out_log.push_back('{int'(bus.m_if.tdata[63:56]), int'(bus.m_if.tdata[15:0]), cyc});
          void'(m_q.pop_front());
        end
        if (exp_rdy[s] && v[s]) begin
          nb.data = bus.s_if[s].tdata;
          nb.last = bus.s_if[s].tlast;
          nb.user = bus.s_if[s].tuser;
          nb.gap  = 0;
          m_q.push_back(nb);
          acc_log.push_back('{s, int'(nb.data[15:0]), cyc});
          if (nb.last) begin
            m_cnt[s]++;
            m_locked = 0;
            m_last   = s;
          end else begin
            m_locked = 1;
            m_owner  = s;
          end
        end
        prev_stall = bus.m_if.tvalid && !bus.m_if_tready;
        prev_data  = bus.m_if.tdata;
        if (!bus.m_if_tready) stall_run++;
        else                  stall_run = 0;
        if (stall_run >= 2 && bus.s_if_tready == '0 && bus.m_if.tvalid) saw_full = 1;
        m_rdy_ok = 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_now_s_tready", 64'(bus.s_if_tready), 64'd0);
    chk("rst_now_m_tvalid", 64'(bus.m_if.tvalid), 64'd0);
    chk("rst_now_m_tlast", 64'(bus.m_if.tlast), 64'd0);
    chk("rst_now_grant_active", 64'(grant_active), 64'd0);
    chk("rst_now_grant_idx", 64'(grant_idx), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic push(int p, int seq, bit last, int gap);
    tx_q[p].push_back(mk(p, seq, last, gap));
  endtask

  task automatic wait_out(int n, int budget, string name);
    int t = 0;
    while (out_log.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk(name, 64'(out_log.size() >= n), 64'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int exp_o2 [6];
    int exp_o3 [6];
    int t;
    exp_o2 = '{0, 1, 2, 0, 1, 2};
    exp_o3 = '{1, 1, 1, 1, 0, 0};

    // 1: port 0 alone, 3-beat TLP, ready high.
    apply_reset();
    push(0, 0, 0, 0); push(0, 1, 0, 0); push(0, 2, 1, 0);
    wait_out(3, 20, "t1_timeout");
    repeat (2) @(posedge clk);
    if (out_log.size() >= 3 && acc_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_port", 64'(out_log[i].port), 64'd0);
        chk("t1_seq", 64'(out_log[i].seq), 64'(i));
        chk("t1_latency", 64'(out_log[i].cyc - acc_log[i].cyc), 64'd1);
      end
      chk("t1_gap01", 64'(out_log[1].cyc - out_log[0].cyc), 64'd1);
      chk("t1_gap12", 64'(out_log[2].cyc - out_log[1].cyc), 64'd1);
    end
`ifdef OFS_PCIE_TX_ARB_PERF_EN
    chk("t1_pkt_cnt0", 64'(pkt_cnt[0]), 64'd1);
`endif

    // 2: ports 0/1/2 single-beat TLPs back to back.
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push(p, r, 1, 0);
    wait_out(6, 30, "t2_timeout");
    if (out_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("t2_order", 64'(out_log[i].port), 64'(exp_o2[i]));
      chk("t2_rate", 64'(out_log[5].cyc - out_log[0].cyc), 64'd5);
    end

    // 3: port 1 locks with a 2-cycle bubble; port 0 waits despite being valid.
    apply_reset();
    push(1, 0, 0, 0); push(1, 1, 0, 0); push(1, 2, 0, 2); push(1, 3, 1, 0);
    @(posedge clk);
    #2;
    push(0, 0, 1, 0); push(0, 1, 1, 0);
    wait_out(6, 40, "t3_timeout");
    if (out_log.size() >= 6)
      for (int i = 0; i < 6; i++) chk("t3_order", 64'(out_log[i].port), 64'(exp_o3[i]));

    // 4: toggling then held-low downstream ready.
    apply_reset();
    rdy_q = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) push(2, i, 1, 0);
    wait_out(8, 60, "t4_timeout");
    repeat (5) @(posedge clk);
    chk("t4_count", 64'(out_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) begin
      chk("t4_port", 64'(out_log[i].port), 64'd2);
      chk("t4_seq", 64'(out_log[i].seq), 64'(i));
    end
    chk("t4_ready_drops_when_full", 64'(saw_full), 64'd1);

    // 5: reset during beat 2 of a 4-beat TLP, then port 0 must win first.
    apply_reset();
    for (int i = 0; i < 4; i++) push(1, i, i == 3, 0);
    t = 0;
    while (acc_log.size() < 1 && t < 20) begin
      @(posedge clk);
      t++;
    end
    chk("t5_first_accept", 64'(acc_log.size() >= 1), 64'd1);
    apply_reset();
    push(2, 0, 1, 0); push(0, 0, 1, 0);
    wait_out(2, 20, "t5_timeout");
    if (out_log.size() >= 2) begin
      chk("t5_first", 64'(out_log[0].port), 64'd0);
      chk("t5_second", 64'(out_log[1].port), 64'd2);
    end

`ifdef OFS_PCIE_TX_ARB_PERF_EN
    // 6: counters, then wrap from all-ones.
    apply_reset();
    for (int i = 0; i < 10; i++) push(2, i, 1, 0);
    wait_out(10, 40, "t6_timeout");
    repeat (2) @(posedge clk);
    chk("t6_cnt2", 64'(pkt_cnt[2]), 64'd10);
    chk("t6_cnt0", 64'(pkt_cnt[0]), 64'd0);
    chk("t6_cnt1", 64'(pkt_cnt[1]), 64'd0);
    @(posedge clk);
    #2;
    force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFF;
    m_cnt[0] = 32'hFFFF_FFFF;
    @(posedge clk);
    #2;
    release dut.g_cnt[0].cnt_q;
    push(0, 0, 1, 0);
    wait_out(11, 20, "t6_wrap_timeout");
    repeat (2) @(posedge clk);
    chk("t6_wrap", 64'(pkt_cnt[0]), 64'd0);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
